// File: rtl/nco_sincos.sv
`default_nettype none
// ============================================================================
// Module   : nco_sincos
// Purpose  : Quadrature NCO. A phase accumulator plus a phase offset address a
//            quarter-wave sine table and produce sin/cos samples with a valid strobe.
// Revision : 1.0  initial release
// ============================================================================
module nco_sincos #(
    parameter int PSZ = 32,
    parameter int ASZ = 10,
    parameter int OSZ = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  sync,
    input  logic                  conj,
    input  logic [PSZ-1:0]        freq,
    input  logic [PSZ-1:0]        poff,
    output logic signed [OSZ-1:0] sin,
    output logic signed [OSZ-1:0] cos,
    output logic                  valid
);

    localparam int AMP   = 2**(OSZ-1) - 1;
    localparam int ROM_N = 2**(ASZ-2);
    localparam int RW    = OSZ - 1;
    localparam int IW    = ASZ - 2;

    // The argument never exceeds pi/2, so the series converges well within 15 terms.
    function automatic real taylor_sin(input real x);
        real term;
        real sum;
        term = x;
        sum  = x;
        for (int n = 1; n < 15; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return sum;
    endfunction

    function automatic logic [ROM_N*RW-1:0] build_rom();
        logic [ROM_N*RW-1:0] tbl;
        real                 ang;
        int                  val;
        tbl = '0;
        for (int i = 0; i < ROM_N; i++) begin
            ang = 2.0 * 3.14159265358979323846 * (real'(i) + 0.5) / real'(2**ASZ);
            val = $rtoi(real'(AMP) * taylor_sin(ang) + 0.5);
            tbl[i*RW +: RW] = RW'(val);
        end
        return tbl;
    endfunction

    localparam logic [ROM_N*RW-1:0] ROM_TBL = build_rom();

    logic [PSZ-1:0] acc_q,   acc_d;
    logic [ASZ-1:0] ph_q,    ph_d;
    logic           conj0_q, conj0_d;
    logic           v0_q,    v0_d;
    logic           v1_q,    v1_d;
    logic           v2_q,    v2_d;
    logic           v3_q,    v3_d;
    logic [IW-1:0]  sidx_q,  sidx_d;
    logic [IW-1:0]  cidx_q,  cidx_d;
    logic           sneg1_q, sneg1_d;
    logic           cneg1_q, cneg1_d;
    logic           sneg2_q, sneg2_d;
    logic           cneg2_q, cneg2_d;
    logic           sneg3_q, sneg3_d;
    logic           cneg3_q, cneg3_d;
    logic [RW-1:0]  srom1_q, srom1_d;
    logic [RW-1:0]  crom1_q, crom1_d;
    logic [RW-1:0]  srom2_q, srom2_d;
    logic [RW-1:0]  crom2_q, crom2_d;
    logic [OSZ-1:0] sin_q,   sin_d;
    logic [OSZ-1:0] cos_q,   cos_d;
    logic           valid_q, valid_d;

    logic [PSZ-1:0] base;
    logic [ASZ-1:0] pc;

    always_comb begin
        base    = sync ? '0 : acc_q;
        acc_d   = acc_q;
        ph_d    = ph_q;
        conj0_d = conj0_q;
        if (en) begin
            acc_d   = base + freq;
            ph_d    = ASZ'((base + poff) >> (PSZ - ASZ));
            conj0_d = conj;
        end
        v0_d = en;

        // Quadrant folding: bit ASZ-2 mirrors the index, bit ASZ-1 flips the sign.
        pc      = ph_q + ASZ'(ROM_N);
        sidx_d  = ph_q[ASZ-2] ? ~ph_q[IW-1:0] : ph_q[IW-1:0];
        cidx_d  = pc[ASZ-2]   ? ~pc[IW-1:0]   : pc[IW-1:0];
        sneg1_d = ph_q[ASZ-1] ^ conj0_q;
        cneg1_d = pc[ASZ-1];
        v1_d    = v0_q;

        srom1_d = ROM_TBL[int'(sidx_q)*RW +: RW];
        crom1_d = ROM_TBL[int'(cidx_q)*RW +: RW];
        sneg2_d = sneg1_q;
        cneg2_d = cneg1_q;
        v2_d    = v1_q;

        srom2_d = srom1_q;
        crom2_d = crom1_q;
        sneg3_d = sneg2_q;
        cneg3_d = cneg2_q;
        v3_d    = v2_q;

        sin_d = sin_q;
        cos_d = cos_q;
        if (v3_q) begin
            sin_d = sneg3_q ? OSZ'(0) - {1'b0, srom2_q} : {1'b0, srom2_q};
            cos_d = cneg3_q ? OSZ'(0) - {1'b0, crom2_q} : {1'b0, crom2_q};
        end
        valid_d = v3_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            ph_q    <= '0;
            conj0_q <= 1'b0;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            sidx_q  <= '0;
            cidx_q  <= '0;
            sneg1_q <= 1'b0;
            cneg1_q <= 1'b0;
            sneg2_q <= 1'b0;
            cneg2_q <= 1'b0;
            sneg3_q <= 1'b0;
            cneg3_q <= 1'b0;
            srom1_q <= '0;
            crom1_q <= '0;
            srom2_q <= '0;
            crom2_q <= '0;
            sin_q   <= '0;
            cos_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            ph_q    <= ph_d;
            conj0_q <= conj0_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            sidx_q  <= sidx_d;
            cidx_q  <= cidx_d;
            sneg1_q <= sneg1_d;
            cneg1_q <= cneg1_d;
            sneg2_q <= sneg2_d;
            cneg2_q <= cneg2_d;
            sneg3_q <= sneg3_d;
            cneg3_q <= cneg3_d;
            srom1_q <= srom1_d;
            crom1_q <= crom1_d;
            srom2_q <= srom2_d;
            crom2_q <= crom2_d;
            sin_q   <= sin_d;
            cos_q   <= cos_d;
            valid_q <= valid_d;
        end
    end

    assign sin   = sin_q;
    assign cos   = cos_q;
    assign valid = valid_q;

endmodule
`default_nettype wire
